// File: rtl/alu_param.sv
// alu_param: parametrised registered ALU with split-operand pairing and a 2-stage multiply.
// Latency: 1 cycle for single-cycle ops, 3 cycles for multiply, counted from the edge completing the operand pair.
// Backpressure: BUSY high in WAIT/MUL drops new inputs; CE low freezes all state. Optional rotates: ALU_ROTATE_EN.
module alu_param #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CE,
   input  logic                MODE,
   input  logic [3:0]          CMD,
   input  logic [1:0]          INP_VALID,
   input  logic [DATA_W-1:0]   OPA,
   input  logic [DATA_W-1:0]   OPB,
   input  logic                CIN,
   output logic [2*DATA_W-1:0] RES,
   output logic                OUT_VALID,
   output logic                BUSY,
   output logic                COUT,
   output logic                OFLOW,
   output logic                G,
   output logic                L,
   output logic                E,
   output logic                ERR
);
   localparam int RW    = 2 * DATA_W;
   localparam int SH_W  = $clog2(DATA_W);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [DATA_W:0]   ONE      = (DATA_W + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL, S_DONE} state_t;

   // Operands a command consumes: bit0 = A, bit1 = B; 00 marks an unused code.
   function automatic logic [1:0] need_f(input logic mode, input logic [3:0] cmd);
      logic [1:0] n;
      n = 2'b00;
      if (mode) begin
         case (cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10: n = 2'b11;
            4'd4, 4'd5:                                n = 2'b01;
            4'd6, 4'd7:                                n = 2'b10;
            default:                                   n = 2'b00;
         endcase
      end else begin
         case (cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: n = 2'b11;
            4'd6, 4'd8, 4'd9:                   n = 2'b01;
            4'd7, 4'd10, 4'd11:                 n = 2'b10;
`ifdef ALU_ROTATE_EN
            4'd12, 4'd13:                       n = 2'b11;
`endif
            default:                            n = 2'b00;
         endcase
      end
      return n;
   endfunction

   function automatic logic is_mul_f(input logic mode, input logic [3:0] cmd);
      return mode && ((cmd == 4'd9) || (cmd == 4'd10));
   endfunction

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]        cmd_q, cmd_d;
   logic              mode_q, mode_d, cin_q, cin_d;
   logic [1:0]        have_q, have_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              tmo_q, tmo_d;
   logic              mul_ph_q, mul_ph_d;
   logic [RW-1:0]     prod_q, prod_d;
   logic [RW-1:0]     res_q, res_d;
   logic [5:0]        flags_q, flags_d;
   logic              out_valid_q, out_valid_d;

   logic [1:0]        need_in;
   logic [RW-1:0]     mul_a, mul_b, prod;
   logic [RW-1:0]     r_res;
   logic              r_cout, r_oflow, r_g, r_l, r_e, r_err;
   logic [DATA_W:0]   ax, bx, cx, t;
   logic [DATA_W-1:0] lr;
   logic              use_t, use_l;

   assign need_in = need_f(MODE, CMD);

`ifdef ALU_ROTATE_EN
   localparam logic [SH_W:0] W_SH = (SH_W + 1)'(DATA_W);
   logic [SH_W:0]     rot_amt;
   logic [DATA_W-1:0] rol_v, ror_v;

   // Rotate A by B's low bits, reduced modulo DATA_W so non-power-of-two widths still rotate
   always_comb begin
      rot_amt = {1'b0, b_q[SH_W-1:0]};
      if (rot_amt >= W_SH) rot_amt = rot_amt - W_SH;
      rol_v = (a_q << rot_amt) | (a_q >> (W_SH - rot_amt));
      ror_v = (a_q >> rot_amt) | (a_q << (W_SH - rot_amt));
   end
`endif

   // Multiply datapath; product is captured in the first MUL cycle
   always_comb begin
      if (cmd_q == 4'd9) begin
         mul_a = RW'({1'b0, a_q} + ONE);
         mul_b = RW'({1'b0, b_q} + ONE);
      end else begin
         mul_a = RW'({a_q, 1'b0});
         mul_b = RW'(b_q);
      end
      prod = mul_a * mul_b;
   end

   // Result and flags for the latched command, consumed in DONE
   always_comb begin
      r_res   = '0;
      r_cout  = 1'b0;
      r_oflow = 1'b0;
      r_g     = 1'b0;
      r_l     = 1'b0;
      r_e     = 1'b0;
      r_err   = 1'b0;
      use_t   = 1'b0;
      use_l   = 1'b0;
      lr      = '0;
      ax      = {1'b0, a_q};
      bx      = {1'b0, b_q};
      cx      = {{DATA_W{1'b0}}, cin_q};
      t       = '0;
      if (tmo_q) begin
         r_err = 1'b1;
      end else if (mode_q) begin
         case (cmd_q)
            4'd0:  begin t = ax + bx;      use_t = 1'b1; r_cout = t[DATA_W]; end
            4'd1:  begin t = ax - bx;      use_t = 1'b1; r_oflow = (a_q < b_q); end
            4'd2:  begin t = ax + bx + cx; use_t = 1'b1; r_cout = t[DATA_W]; end
            4'd3:  begin t = ax - bx - cx; use_t = 1'b1; r_oflow = (ax < (bx + cx)); end
            4'd4:  begin t = ax + ONE;     use_t = 1'b1; r_cout = t[DATA_W]; end
            4'd5:  begin t = ax - ONE;     use_t = 1'b1; r_oflow = (a_q == '0); end
            4'd6:  begin t = bx + ONE;     use_t = 1'b1; r_cout = t[DATA_W]; end
            4'd7:  begin t = bx - ONE;     use_t = 1'b1; r_oflow = (b_q == '0); end
            4'd8:  begin r_g = (a_q > b_q); r_l = (a_q < b_q); r_e = (a_q == b_q); end
            4'd9, 4'd10: r_res = prod_q;
            default: r_err = 1'b1;
         endcase
      end else begin
         use_l = 1'b1;
         case (cmd_q)
            4'd0:  lr = a_q & b_q;
            4'd1:  lr = ~(a_q & b_q);
            4'd2:  lr = a_q | b_q;
            4'd3:  lr = ~(a_q | b_q);
            4'd4:  lr = a_q ^ b_q;
            4'd5:  lr = ~(a_q ^ b_q);
            4'd6:  lr = ~a_q;
            4'd7:  lr = ~b_q;
            4'd8:  lr = a_q >> 1;
            4'd9:  lr = a_q << 1;
            4'd10: lr = b_q >> 1;
            4'd11: lr = b_q << 1;
`ifdef ALU_ROTATE_EN
            4'd12: begin lr = rol_v; r_err = |(b_q >> SH_W); end
            4'd13: begin lr = ror_v; r_err = |(b_q >> SH_W); end
`endif
            default: begin use_l = 1'b0; r_err = 1'b1; end
         endcase
      end
      if (use_t) r_res = RW'(t);
      if (use_l) r_res = RW'(lr);
   end

   // Operand pairing FSM: next state, operand latches, timer and output register loads
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cmd_d       = cmd_q;
      mode_d      = mode_q;
      cin_d       = cin_q;
      have_d      = have_q;
      timer_d     = timer_q;
      tmo_d       = tmo_q;
      mul_ph_d    = mul_ph_q;
      prod_d      = prod_q;
      res_d       = res_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      if (CE) begin
         case (state_q)
            S_IDLE: begin
               if (INP_VALID != 2'b00) begin
                  if (need_in == 2'b00 || (INP_VALID & need_in) == need_in || need_in == 2'b11) begin
                     cmd_d   = CMD;
                     mode_d  = MODE;
                     cin_d   = CIN;
                     a_d     = INP_VALID[0] ? OPA : '0;
                     b_d     = INP_VALID[1] ? OPB : '0;
                     have_d  = INP_VALID;
                     tmo_d   = 1'b0;
                     timer_d = '0;
                     if (need_in == 2'b00)                         state_d = S_DONE;
                     else if ((INP_VALID & need_in) == need_in)    state_d = is_mul_f(MODE, CMD) ? S_MUL : S_DONE;
                     else                                          state_d = S_WAIT;
                  end
                  // single-operand op without its own operand: nothing to do, stay idle
               end
            end
            S_WAIT: begin
               // The missing operand wins even on the expiry edge
               if ((INP_VALID & ~have_q) != 2'b00) begin
                  if (!have_q[0]) a_d = OPA;
                  else            b_d = OPB;
                  have_d  = 2'b11;
                  timer_d = '0;
                  state_d = is_mul_f(mode_q, cmd_q) ? S_MUL : S_DONE;
               end else if (timer_q == TMO_LAST) begin
                  tmo_d   = 1'b1;
                  timer_d = '0;
                  state_d = S_DONE;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_MUL: begin
               if (!mul_ph_q) begin
                  prod_d   = prod;
                  mul_ph_d = 1'b1;
               end else begin
                  mul_ph_d = 1'b0;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               res_d       = r_res;
               flags_d     = {r_cout, r_oflow, r_g, r_l, r_e, r_err};
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers; reset aborts any operation in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cmd_q       <= '0;
         mode_q      <= 1'b0;
         cin_q       <= 1'b0;
         have_q      <= '0;
         timer_q     <= '0;
         tmo_q       <= 1'b0;
         mul_ph_q    <= 1'b0;
         prod_q      <= '0;
         res_q       <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cmd_q       <= cmd_d;
         mode_q      <= mode_d;
         cin_q       <= cin_d;
         have_q      <= have_d;
         timer_q     <= timer_d;
         tmo_q       <= tmo_d;
         mul_ph_q    <= mul_ph_d;
         prod_q      <= prod_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign RES       = res_q;
   assign OUT_VALID = out_valid_q;
   assign BUSY      = (state_q == S_WAIT) || (state_q == S_MUL);
   assign {COUT, OFLOW, G, L, E, ERR} = flags_q;

endmodule

// File: tb/tb_alu_param.sv
// tb_alu_param: directed vectors against a behavioural ALU model plus literal checks.
// Latency: expected pulses are scheduled by absolute cycle number from the accepting edge.
// Backpressure: inputs issued while busy are not modelled as queued.
module tb_alu_param;
   localparam int W = 8;

   logic          CLK = 1'b0;
   logic          RST, CE, MODE, CIN;
   logic [3:0]    CMD;
   logic [1:0]    INP_VALID;
   logic [W-1:0]  OPA, OPB;
   logic [2*W-1:0] RES;
   logic          OUT_VALID, BUSY, COUT, OFLOW, G, L, E, ERR;

   alu_param #(.DATA_W(W), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
      .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .OUT_VALID(OUT_VALID), .BUSY(BUSY),
      .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] res;
      logic        cout, oflow, g, l, e, err;
      int          due;
   } exp_t;

   exp_t q[$];
   exp_t last, cur;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   chk_on = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, cyc);
   endtask

   function automatic exp_t zero_exp();
      exp_t x;
      x.res = '0; x.cout = 0; x.oflow = 0; x.g = 0; x.l = 0; x.e = 0; x.err = 0; x.due = 0;
      return x;
   endfunction

   // What the ALU must produce for a fully-paired command, in plain integer arithmetic
   function automatic exp_t model(input bit m, input int c, input int a, input int b, input bit ci);
      exp_t x;
      int   s;
      x = zero_exp();
      if (m) begin
         case (c)
            0:  begin s = a + b;      x.res = 16'(s); x.cout = (s > 255); end
            1:  begin x.res = 16'((a - b) & 'h1FF);      x.oflow = (a < b); end
            2:  begin s = a + b + ci; x.res = 16'(s); x.cout = (s > 255); end
            3:  begin x.res = 16'((a - b - ci) & 'h1FF); x.oflow = (a < b + ci); end
            4:  begin s = a + 1;      x.res = 16'(s); x.cout = (s > 255); end
            5:  begin x.res = 16'((a - 1) & 'h1FF);      x.oflow = (a == 0); end
            6:  begin s = b + 1;      x.res = 16'(s); x.cout = (s > 255); end
            7:  begin x.res = 16'((b - 1) & 'h1FF);      x.oflow = (b == 0); end
            8:  begin x.g = (a > b); x.l = (a < b); x.e = (a == b); end
            9:  x.res = 16'(((a + 1) * (b + 1)) % 65536);
            10: x.res = 16'((a * 2 * b) % 65536);
            default: x.err = 1;
         endcase
      end else begin
         case (c)
            0:  x.res = 16'(a & b);
            1:  x.res = 16'(~(a & b) & 255);
            2:  x.res = 16'(a | b);
            3:  x.res = 16'(~(a | b) & 255);
            4:  x.res = 16'(a ^ b);
            5:  x.res = 16'(~(a ^ b) & 255);
            6:  x.res = 16'(~a & 255);
            7:  x.res = 16'(~b & 255);
            8:  x.res = 16'(a / 2);
            9:  x.res = 16'((a * 2) % 256);
            10: x.res = 16'(b / 2);
            11: x.res = 16'((b * 2) % 256);
`ifdef ALU_ROTATE_EN
            12: begin x.res = 16'(((a << (b % 8)) | (a >> (8 - b % 8))) & 255); x.err = (b >= 8); end
            13: begin x.res = 16'(((a >> (b % 8)) | (a << (8 - b % 8))) & 255); x.err = (b >= 8); end
`endif
            default: x.err = 1;
         endcase
      end
      return x;
   endfunction

   // Reset discards every pending result and clears the held outputs
   always @(posedge RST) begin
      q.delete();
      last = zero_exp();
   end

   // Every cycle: OUT_VALID exactly when a result is due, RES/flags equal the most recent result
   always @(negedge CLK) begin
      if (chk_on && !RST) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            cur  = q.pop_front();
            last = cur;
            chk("out_valid_pulse", 32'(OUT_VALID), 32'd1);
         end else begin
            chk("out_valid_quiet", 32'(OUT_VALID), 32'd0);
         end
         chk("res", 32'(RES), 32'(last.res));
         chk("flags", 32'({COUT, OFLOW, G, L, E, ERR}),
             32'({last.cout, last.oflow, last.g, last.l, last.e, last.err}));
      end
   end

   task automatic drive(input bit m, input int c, input logic [1:0] iv, input int a, input int b,
                        input bit ci, output int acc);
      @(negedge CLK);
      MODE = m; CMD = c[3:0]; INP_VALID = iv; OPA = a[7:0]; OPB = b[7:0]; CIN = ci;
      @(posedge CLK);
      #1;
      acc = cyc;
      INP_VALID = 2'b00;
   endtask

   task automatic push(input exp_t x, input int due);
      exp_t y;
      y = x;
      y.due = due;
      q.push_back(y);
   endtask

   // Issue a complete command and return just after its OUT_VALID edge
   task automatic run_op(input bit m, input int c, input logic [1:0] iv, input int a, input int b, input bit ci);
      int acc, lat;
      lat = (m && (c == 9 || c == 10)) ? 3 : 1;
      drive(m, c, iv, a, b, ci, acc);
      push(model(m, c, a, b, ci), acc + lat);
      repeat (lat) @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int   acc, acc2;
      exp_t tx;
      RST = 1'b1; CE = 1'b1; MODE = 1'b0; CMD = '0; INP_VALID = '0; OPA = '0; OPB = '0; CIN = 1'b0;
      last = zero_exp();
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_res", 32'(RES), 32'd0);
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_flags", 32'({COUT, OFLOW, G, L, E, ERR}), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      chk_on = 1'b1;

      // Arithmetic
      run_op(1, 0, 2'b11, 'hFF, 'h01, 0);
      chk("add_res", 32'(RES), 32'h100);
      chk("add_cout", 32'(COUT), 32'd1);
      chk("add_valid", 32'(OUT_VALID), 32'd1);
      run_op(1, 2, 2'b11, 'h7F, 'h80, 1);
      run_op(1, 3, 2'b11, 'h05, 'h05, 1);
      chk("subc_res", 32'(RES), 32'h1FF);
      chk("subc_oflow", 32'(OFLOW), 32'd1);
      run_op(1, 4, 2'b01, 'hFF, 'h00, 0);
      run_op(1, 5, 2'b01, 'h00, 'h00, 0);
      run_op(1, 6, 2'b10, 'h00, 'h41, 0);
      run_op(1, 7, 2'b10, 'h00, 'h10, 0);
      run_op(1, 8, 2'b11, 'h10, 'h20, 0);
      chk("cmp_glе", 32'({G, L, E}), 32'b010);
      chk("cmp_res", 32'(RES), 32'd0);
      run_op(1, 1, 2'b11, 'h10, 'h20, 0);
      chk("sub_oflow", 32'(OFLOW), 32'd1);
      run_op(1, 8, 2'b11, 'h33, 'h33, 0);
      run_op(1, 10, 2'b11, 'h05, 'h03, 0);
      chk("mul10_res", 32'(RES), 32'h1E);
      run_op(1, 9, 2'b11, 'hFF, 'hFF, 0);

      // Logical
      for (int c = 0; c < 12; c++) run_op(0, c, 2'b11, 'hA5, 'h3C, 0);
      run_op(0, 1, 2'b11, 'hA5, 'h3C, 0);
      chk("nand_res", 32'(RES), 32'hDB);
      run_op(0, 9, 2'b01, 'hA5, 'h00, 0);
      chk("shl1a_res", 32'(RES), 32'h4A);

      // Unused codes
      run_op(1, 12, 2'b11, 'h12, 'h34, 0);
      chk("unused_err", 32'(ERR), 32'd1);
      chk("unused_res", 32'(RES), 32'd0);
      run_op(0, 15, 2'b01, 'h12, 'h34, 0);

      // Rotates
      run_op(0, 12, 2'b11, 'h81, 'h01, 0);
`ifdef ALU_ROTATE_EN
      chk("rol_res", 32'(RES), 32'h03);
      chk("rol_err", 32'(ERR), 32'd0);
      run_op(0, 12, 2'b11, 'h81, 'h10, 0);
      chk("rol_range_err", 32'(ERR), 32'd1);
      run_op(0, 13, 2'b11, 'h81, 'h01, 0);
      chk("ror_res", 32'(RES), 32'hC0);
`else
      chk("rol_off_err", 32'(ERR), 32'd1);
      chk("rol_off_res", 32'(RES), 32'd0);
      run_op(0, 13, 2'b11, 'h81, 'h01, 0);
`endif

      // Split operands into a multiply: BUSY held, result 3 cycles after B
      drive(1, 9, 2'b01, 'h0F, 'h00, 0, acc);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("split_busy_wait", 32'(BUSY), 32'd1);
      end
      drive(1, 9, 2'b10, 'h00, 'h02, 0, acc2);
      push(model(1, 9, 'h0F, 'h02, 0), acc2 + 3);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         chk("split_busy_mul", 32'(BUSY), 32'd1);
      end
      repeat (2) @(posedge CLK);
      #1;
      chk("split_valid", 32'(OUT_VALID), 32'd1);
      chk("split_res", 32'(RES), 32'h30);

      // Timeout: missing operand never arrives
      drive(1, 0, 2'b01, 'h44, 'h00, 0, acc);
      tx = zero_exp();
      tx.err = 1;
      push(tx, acc + 17);
      repeat (17) @(posedge CLK);
      #1;
      chk("tmo_valid", 32'(OUT_VALID), 32'd1);
      chk("tmo_err", 32'(ERR), 32'd1);
      chk("tmo_res", 32'(RES), 32'd0);

      // Operand arrives on the expiry edge: operand wins
      drive(1, 0, 2'b01, 'h20, 'h00, 0, acc);
      repeat (15) @(negedge CLK);
      drive(1, 0, 2'b10, 'h00, 'h03, 0, acc2);
      push(model(1, 0, 'h20, 'h03, 0), acc2 + 1);
      @(posedge CLK);
      #1;
      chk("edge_err", 32'(ERR), 32'd0);
      chk("edge_res", 32'(RES), 32'h23);

      // INP_VALID=11 in WAIT: latched A kept, CMD/MODE ignored
      drive(1, 0, 2'b01, 'h05, 'h00, 0, acc);
      drive(0, 1, 2'b11, 'h99, 'h03, 0, acc2);
      push(model(1, 0, 'h05, 'h03, 0), acc2 + 1);
      @(posedge CLK);
      #1;
      chk("wait11_res", 32'(RES), 32'h08);

      // CE low for two cycles stretches the latency
      drive(1, 0, 2'b11, 'h01, 'h02, 0, acc);
      push(model(1, 0, 'h01, 'h02, 0), acc + 3);
      @(negedge CLK); CE = 1'b0;
      @(negedge CLK);
      @(negedge CLK); CE = 1'b1;
      @(posedge CLK);
      #1;
      chk("ce_res", 32'(RES), 32'h03);

      // Command issued during MUL is dropped
      drive(1, 9, 2'b11, 'h02, 'h03, 0, acc);
      push(model(1, 9, 'h02, 'h03, 0), acc + 3);
      drive(1, 0, 2'b11, 'h11, 'h11, 0, acc2);
      repeat (2) @(posedge CLK);
      #1;
      chk("busy_drop_res", 32'(RES), 32'h0C);

      // Reset during MUL aborts with no pulse
      drive(1, 9, 2'b11, 'h0F, 'h02, 0, acc);
      push(model(1, 9, 'h0F, 'h02, 0), acc + 3);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("abort_res", 32'(RES), 32'd0);
      chk("abort_valid", 32'(OUT_VALID), 32'd0);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_flags", 32'({COUT, OFLOW, G, L, E, ERR}), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(posedge CLK);
      run_op(1, 0, 2'b11, 'h01, 'h01, 0);
      chk("post_rst_res", 32'(RES), 32'h02);

      repeat (3) @(posedge CLK);
      #1;
      chk("all_results_seen", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_param.md
# alu_param

Parametrised, registered successor to the team's 8-bit ALU DUT. Operand width is generic, and multiply commands run as a multi-cycle operation. An operand-pairing state machine accepts OPA and OPB on different cycles, within a bounded window. The block sits directly under the existing class-based testbench (driver → DUT → monitor) and replaces the fixed-width combinational ALU.

## Interface
- DATA_W, 8, operand width in bits (≥4)
- TIMEOUT, 16, maximum cycles spent in WAIT for the missing operand (≥1)
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CE  in  1  clock enable; low freezes all state and outputs
- MODE  in  1  1 = arithmetic, 0 = logical
- CMD  in  4  operation select
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- OPA, OPB  in  DATA_W  operands
- CIN  in  1  carry in
- RES  out  2*DATA_W  result, zero-extended for non-multiply ops
- OUT_VALID  out  1  one-cycle pulse, RES and flags valid
- BUSY  out  1  high in WAIT and MUL states; inputs ignored
- COUT, OFLOW, G, L, E, ERR  out  1 each  status flags

## Operation
- FSM states: IDLE, WAIT, MUL, DONE.
- IDLE, command acceptance (CE=1, BUSY=0):
  - All operands required by CMD present → go to DONE, or to MUL for multiply ops.
  - Two-operand op with only one valid bit set → latch that operand, CMD, MODE and CIN; go to WAIT.
  - INP_VALID=00 → stay in IDLE, no output.
- WAIT:
  - Watch the missing valid bit. On arrival, latch the operand and go to DONE or MUL.
  - Timer counts CE-qualified cycles. After TIMEOUT cycles without the operand → DONE with ERR=1 and RES=0.
  - CMD and MODE inputs are ignored while in WAIT.
- MUL: lasts 2 cycles (product register, then output register). Then go to DONE.
- DONE: drive the output registers, OUT_VALID=1, return to IDLE. A new command can be accepted on the next cycle.
- Arithmetic (MODE=1):
  - 0 ADD, 1 SUB, 2 ADD+CIN, 3 SUB−CIN.
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B. These need only their own operand.
  - 8 CMP: sets G/L/E, RES=0.
  - 9 MUL (A+1)*(B+1), 10 MUL (A<<1)*B. Both modulo 2^(2*DATA_W).
- Arithmetic flags:
  - COUT = bit DATA_W of an add result.
  - OFLOW = borrow out for SUB/SUB−CIN/DEC; also set when A<B on SUB.
  - RES holds DATA_W+1 bits for add/sub.
- Logical (MODE=0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- Logical, single-operand:
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - Results are DATA_W bits; shifts drop the shifted-out bit.
- Logical, rotates (see Configuration): 12 ROL_A_B, 13 ROR_A_B rotate A by B[clog2(DATA_W)-1:0].
- Rotate error: ROL/ROR with any OPB bit above B[clog2(DATA_W)-1:0] set → ERR=1, result still produced.
- Unused CMD codes → ERR=1, RES=0, OUT_VALID pulses.
- Flags not defined for an op are 0.

## Timing
- Reset: all outputs 0, FSM=IDLE, timer=0, latches cleared. Reset asserted mid-WAIT or mid-MUL aborts the operation with no OUT_VALID.
- Latency, measured from the accepting edge to the OUT_VALID edge:
  - Single-cycle ops: 1 cycle.
  - Multiply: 3 cycles.
  - Split operands: counted from the edge that completes the pair.
- OUT_VALID is high for exactly one cycle. RES and flags hold their value until the next OUT_VALID.
- CE=0 in any state: no transitions, timer holds, OUT_VALID held low that cycle.
- Second operand arriving on the same edge the timer expires: the operand wins, no ERR.
- Inputs presented while BUSY=1 are dropped; the bench must not expect them to be queued.
- INP_VALID=11 arriving in WAIT uses only the missing operand; the latched operand is kept.

## Configuration
- ALU_ROTATE_EN defined: CMD 12 and 13 in logical mode perform rotates as above.
- ALU_ROTATE_EN undefined: the rotate logic is not synthesised, and CMD 12/13 behave as unused codes (ERR=1, RES=0).

## Test plan
All scenarios use DATA_W=8 and TIMEOUT=16.
- ADD: MODE=1, CMD=0, OPA=0xFF, OPB=0x01, INP_VALID=11 → next cycle RES=0x100, COUT=1, OUT_VALID pulse.
- Split operands: CMD=9, OPA=0x0F with INP_VALID=01; 5 cycles later OPB=0x02 with INP_VALID=10 → BUSY high throughout; RES=0x0030 three cycles after the OPB edge.
- Timeout: MODE=1, CMD=0, INP_VALID=01 only, then 00 → OUT_VALID with ERR=1 and RES=0 on the 17th cycle after acceptance.
- CMP and SUB: CMP with OPA=0x10, OPB=0x20 → L=1, G=E=0; then SUB with the same operands → OFLOW=1.
- Rotate with the macro defined: MODE=0, CMD=12, OPA=0x81, OPB=0x01 → RES=0x03, ERR=0. With OPB=0x10 → ERR=1. With the macro undefined → ERR=1, RES=0.
- Reset mid-operation: assert RST during MUL → no OUT_VALID pulse, all outputs 0. A later ADD 0x01+0x01 → RES=0x02.
